color_scan_sequencer: RTL and testbench

- Controller for the TCS3200-style colour sensor front end.
- On request, it sequences the filter-select lines through red, green and blue, and applies a settle interval after each filter change.
- It counts synchronised `cs_out` rising edges over a fixed window in the `clk_1MHz` domain, then classifies the triple into a colour code.
- Results go to the line-follower FSM through a valid/ack handshake; the block replaces free-running filter rotation with a request-driven scan.

---
 rtl/color_pkg.sv | 53 +++++
 rtl/freq_edge_counter.sv | 48 ++++
 rtl/color_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_color_scan_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared encodings for the colour scan sequencer: filter selects, colour codes,
// scan FSM states and the colour classification rule.
package color_pkg;

    // S2/S3 filter select encodings
    localparam logic [1:0] RED_FILTER   = 2'd0;
    localparam logic [1:0] BLUE_FILTER  = 2'd1;
    localparam logic [1:0] CLEAR_FILTER = 2'd2;
    localparam logic [1:0] GREEN_FILTER = 2'd3;

    // Colour result encodings
    localparam logic [1:0] CLEAR_COLOR  = 2'd0;
    localparam logic [1:0] RED_COLOR    = 2'd1;
    localparam logic [1:0] GREEN_COLOR  = 2'd2;
    localparam logic [1:0] BLUE_COLOR   = 2'd3;

    // S0/S1 scaling used while the sensor is running
    localparam logic [1:0] SCALER_RUN   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_ADVANCE,
        ST_CLASSIFY,
        ST_HOLD
    } scan_state_e;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } chan_e;

    // A single dominant channel picks the colour; anything else keeps the last one
    function automatic logic [1:0] classify(
        input logic       hi_r,
        input logic       hi_g,
        input logic       hi_b,
        input logic [1:0] prev
    );
        logic [1:0] res;
        res = prev;
        case ({hi_r, hi_g, hi_b})
            3'b100:  res = RED_COLOR;
            3'b010:  res = GREEN_COLOR;
            3'b001:  res = BLUE_COLOR;
            default: res = prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/freq_edge_counter.sv
// Synchronises the asynchronous sensor output, detects rising edges and counts
// them in a saturating counter. Edge-to-count latency is three clocks.
module freq_edge_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise  = r_sync[1] & ~r_prev;
    assign o_cnt   = r_cnt;
    assign o_sat_c = (r_cnt == CNT_MAX);

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_sig};
            r_prev <= r_sync[1];
        end
    end

    // Saturating edge counter; clear has priority over counting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && w_rise && !o_sat_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/color_scan_sequencer.sv
// Request-driven TCS3200 colour scan: steps the filter through red, green and
// blue, settles, counts sensor edges over a fixed window, classifies the triple
// and hands the result over a valid/ack handshake.
// Optional: define COLOR_SCAN_PWRDN_EN to power the sensor down (cs_scaler=0)
// in IDLE/HOLD and stretch the first settle interval for wake-up.
module color_scan_sequencer
    import color_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 10000,
    parameter int unsigned SETTLE_CYCLES = 100,
    parameter int unsigned THRESH        = 100,
    parameter int unsigned CNT_W         = 10
) (
    input  logic             clk_1MHz,
    input  logic             reset,
    input  logic             cs_out,
    input  logic             en,
    input  logic             start,
    input  logic             result_ack,
    output logic [1:0]       filter,
    output logic [1:0]       cs_scaler,
    output logic             busy,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [1:0]       color,
    output logic             result_valid,
    output logic             overflow
);

    localparam int unsigned SETTLE_WAKE = 2 * SETTLE_CYCLES;
    localparam int unsigned TMR_MAX     = (WINDOW_CYCLES > SETTLE_WAKE) ? WINDOW_CYCLES : SETTLE_WAKE;
    localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

    scan_state_e      r_state, w_state_nxt;
    chan_e            r_chan, w_chan_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic             r_wake, w_wake_nxt;
    logic [1:0]       r_filter, w_filter_nxt;
    logic [1:0]       r_scaler, w_scaler_nxt;
    logic [1:0]       r_color, w_color_nxt;
    logic [1:0]       r_prev_color, w_prev_color_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [CNT_W-1:0] r_ch_red, w_ch_red_nxt;
    logic [CNT_W-1:0] r_ch_green, w_ch_green_nxt;
    logic [CNT_W-1:0] r_ch_blue, w_ch_blue_nxt;
    logic [CNT_W-1:0] r_red_cnt, w_red_cnt_nxt;
    logic [CNT_W-1:0] r_green_cnt, w_green_cnt_nxt;
    logic [CNT_W-1:0] r_blue_cnt, w_blue_cnt_nxt;

    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt;
    logic             w_sat;
    logic             w_settle_last;
    logic             w_window_last;
    logic             w_hi_red, w_hi_green, w_hi_blue;

    freq_edge_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk   (clk_1MHz),
        .i_rst   (reset),
        .i_sig   (cs_out),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_cnt   (w_cnt),
        .o_sat_c (w_sat)
    );

    // The first settle after wake-up runs twice as long
    assign w_settle_last = r_wake ? (r_tmr == TMR_W'(SETTLE_WAKE - 1))
                                  : (r_tmr == TMR_W'(SETTLE_CYCLES - 1));
    assign w_window_last = (r_tmr == TMR_W'(WINDOW_CYCLES - 1));
    assign w_hi_red      = (32'(r_ch_red)   >= THRESH);
    assign w_hi_green    = (32'(r_ch_green) >= THRESH);
    assign w_hi_blue     = (32'(r_ch_blue)  >= THRESH);

    assign filter        = r_filter;
    assign cs_scaler     = r_scaler;
    assign busy          = r_busy;
    assign red_cnt       = r_red_cnt;
    assign green_cnt     = r_green_cnt;
    assign blue_cnt      = r_blue_cnt;
    assign color         = r_color;
    assign result_valid  = r_valid;
    assign overflow      = r_ovf;

    // Next-state and next-output logic for the scan sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_chan_nxt       = r_chan;
        w_tmr_nxt        = r_tmr;
        w_wake_nxt       = r_wake;
        w_filter_nxt     = r_filter;
        w_color_nxt      = r_color;
        w_prev_color_nxt = r_prev_color;
        w_busy_nxt       = r_busy;
        w_valid_nxt      = r_valid;
        w_ovf_nxt        = r_ovf;
        w_ch_red_nxt     = r_ch_red;
        w_ch_green_nxt   = r_ch_green;
        w_ch_blue_nxt    = r_ch_blue;
        w_red_cnt_nxt    = r_red_cnt;
        w_green_cnt_nxt  = r_green_cnt;
        w_blue_cnt_nxt   = r_blue_cnt;
        w_cnt_clr        = 1'b0;
        w_cnt_en         = 1'b0;
        w_scaler_nxt     = SCALER_RUN;

        case (r_state)
            ST_IDLE: begin
                if (start || en) begin
                    w_state_nxt  = ST_SETTLE;
                    w_chan_nxt   = CH_R;
                    w_filter_nxt = RED_FILTER;
                    w_busy_nxt   = 1'b1;
                    w_ovf_nxt    = 1'b0;
                    w_tmr_nxt    = '0;
                    w_cnt_clr    = 1'b1;
`ifdef COLOR_SCAN_PWRDN_EN
                    w_wake_nxt   = 1'b1;
`endif
                end
            end

            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = ST_MEASURE;
                    w_tmr_nxt   = '0;
                    w_wake_nxt  = 1'b0;
                end else begin
                    w_tmr_nxt   = r_tmr + TMR_W'(1);
                end
            end

            ST_MEASURE: begin
                w_cnt_en  = 1'b1;
                w_ovf_nxt = r_ovf | w_sat;
                if (w_window_last) begin
                    w_state_nxt = ST_ADVANCE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt   = r_tmr + TMR_W'(1);
                end
            end

            ST_ADVANCE: begin
                w_cnt_clr = 1'b1;
                w_ovf_nxt = r_ovf | w_sat;
                case (r_chan)
                    CH_R: begin
                        w_ch_red_nxt   = w_cnt;
                        w_chan_nxt     = CH_G;
                        w_filter_nxt   = GREEN_FILTER;
                        w_state_nxt    = ST_SETTLE;
                    end
                    CH_G: begin
                        w_ch_green_nxt = w_cnt;
                        w_chan_nxt     = CH_B;
                        w_filter_nxt   = BLUE_FILTER;
                        w_state_nxt    = ST_SETTLE;
                    end
                    default: begin
                        w_ch_blue_nxt  = w_cnt;
                        w_filter_nxt   = CLEAR_FILTER;
                        w_state_nxt    = ST_CLASSIFY;
                    end
                endcase
            end

            ST_CLASSIFY: begin
                w_color_nxt      = classify(w_hi_red, w_hi_green, w_hi_blue, r_prev_color);
                w_prev_color_nxt = w_color_nxt;
                w_red_cnt_nxt    = r_ch_red;
                w_green_cnt_nxt  = r_ch_green;
                w_blue_cnt_nxt   = r_ch_blue;
                w_valid_nxt      = 1'b1;
                w_busy_nxt       = 1'b0;
                w_state_nxt      = ST_HOLD;
            end

            ST_HOLD: begin
                if (result_ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef COLOR_SCAN_PWRDN_EN
        if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD)) begin
            w_scaler_nxt = '0;
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk_1MHz or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_chan       <= CH_R;
            r_tmr        <= '0;
            r_wake       <= 1'b0;
            r_filter     <= CLEAR_FILTER;
            r_scaler     <= SCALER_RUN;
            r_color      <= CLEAR_COLOR;
            r_prev_color <= CLEAR_COLOR;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
            r_ch_red     <= '0;
            r_ch_green   <= '0;
            r_ch_blue    <= '0;
            r_red_cnt    <= '0;
            r_green_cnt  <= '0;
            r_blue_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_chan       <= w_chan_nxt;
            r_tmr        <= w_tmr_nxt;
            r_wake       <= w_wake_nxt;
            r_filter     <= w_filter_nxt;
            r_scaler     <= w_scaler_nxt;
            r_color      <= w_color_nxt;
            r_prev_color <= w_prev_color_nxt;
            r_busy       <= w_busy_nxt;
            r_valid      <= w_valid_nxt;
            r_ovf        <= w_ovf_nxt;
            r_ch_red     <= w_ch_red_nxt;
            r_ch_green   <= w_ch_green_nxt;
            r_ch_blue    <= w_ch_blue_nxt;
            r_red_cnt    <= w_red_cnt_nxt;
            r_green_cnt  <= w_green_cnt_nxt;
            r_blue_cnt   <= w_blue_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Bench for color_scan_sequencer with shortened windows. A sensor model drives
// cs_out as a square wave whose period depends on the selected filter; expected
// results come from the counting/classification rules and are checked by a
// scoreboard monitor whenever result_valid rises.
module tb_color_scan_sequencer;

    localparam int unsigned W  = 200;
    localparam int unsigned S  = 10;
    localparam int unsigned TH = 20;
    localparam int unsigned CW = 6;
    localparam int MAXC = (1 << CW) - 1;
`ifdef COLOR_SCAN_PWRDN_EN
    localparam int LAT         = 3 * (S + W + 1) + 1 + S;
    localparam int HOLD_SCALER = 0;
`else
    localparam int LAT         = 3 * (S + W + 1) + 1;
    localparam int HOLD_SCALER = 2;
`endif

    logic          clk, reset, cs_out, en, start, result_ack;
    logic [1:0]    filter, cs_scaler, color;
    logic          busy, result_valid, overflow;
    logic [CW-1:0] red_cnt, green_cnt, blue_cnt;

    typedef struct {
        int     color;
        int     r;
        int     g;
        int     b;
        int     ovf;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    int     m_prev  = 0;
    int     per_r   = 0;
    int     per_g   = 0;
    int     per_b   = 0;
    int     ptab[12] = '{0, 2, 4, 5, 8, 10, 20, 25, 40, 50, 100, 200};

    color_scan_sequencer #(
        .WINDOW_CYCLES (W),
        .SETTLE_CYCLES (S),
        .THRESH        (TH),
        .CNT_W         (CW)
    ) dut (
        .clk_1MHz     (clk),
        .reset        (reset),
        .cs_out       (cs_out),
        .en           (en),
        .start        (start),
        .result_ack   (result_ack),
        .filter       (filter),
        .cs_scaler    (cs_scaler),
        .busy         (busy),
        .red_cnt      (red_cnt),
        .green_cnt    (green_cnt),
        .blue_cnt     (blue_cnt),
        .color        (color),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cyc=%0d required completion", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int per_of(input logic [1:0] f);
        case (f)
            2'd0:    return per_r;
            2'd1:    return per_b;
            2'd3:    return per_g;
            default: return 0;
        endcase
    endfunction

    // Edges in a window whose length is a multiple of the period, clamped
    function automatic int exp_cnt(input int p);
        int c;
        if (p == 0) return 0;
        c = int'(W) / p;
        return (c > MAXC) ? MAXC : c;
    endfunction

    // Reference model: queue the result a scan issued at cycle c0 must produce
    task automatic push_exp(input longint c0);
        exp_t e;
        int   nh;
        e.r = exp_cnt(per_r);
        e.g = exp_cnt(per_g);
        e.b = exp_cnt(per_b);
        nh  = int'(e.r >= int'(TH)) + int'(e.g >= int'(TH)) + int'(e.b >= int'(TH));
        if (nh == 1) begin
            if (e.r >= int'(TH))      m_prev = 1;
            else if (e.g >= int'(TH)) m_prev = 2;
            else                      m_prev = 3;
        end
        e.color = m_prev;
        e.ovf   = int'(e.r == MAXC || e.g == MAXC || e.b == MAXC);
        e.cyc   = c0 + 1 + LAT;
        sb.push_back(e);
    endtask

    // Sensor model: square wave restarted whenever the filter changes
    initial begin : sensor
        int         ph;
        int         p;
        logic [1:0] lf;
        cs_out = 1'b0;
        ph     = 0;
        lf     = 2'd2;
        forever begin
            @(negedge clk);
            if (filter != lf) begin
                lf = filter;
                ph = 0;
            end
            p = per_of(lf);
            if (p == 0) begin
                cs_out = 1'b0;
            end else begin
                cs_out = (ph < p / 2);
                ph     = (ph + 1) % p;
            end
        end
    end

    // Scoreboard monitor: compare each new result against the queued expectation
    initial begin : monitor
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !pv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("color", color, e.color);
                    chk("red_cnt", red_cnt, e.r);
                    chk("green_cnt", green_cnt, e.g);
                    chk("blue_cnt", blue_cnt, e.b);
                    chk("overflow", overflow, e.ovf);
                    chk("busy_at_valid", busy, 0);
                    chk("filter_at_valid", filter, 2);
                    chk("scaler_in_hold", cs_scaler, HOLD_SCALER);
                end
            end
            pv = result_valid;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_filter"}, filter, 2);
        chk({tag, "_scaler"}, cs_scaler, 2);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_color"}, color, 0);
        chk({tag, "_red"}, red_cnt, 0);
        chk({tag, "_green"}, green_cnt, 0);
        chk({tag, "_blue"}, blue_cnt, 0);
    endtask

    task automatic start_scan(input bit use_en);
        push_exp(cyc);
        if (use_en) en = 1'b1;
        else        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!result_valid && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_ack(input bit restart, input int hold);
        repeat (hold) @(negedge clk);
        result_ack = 1'b1;
        if (restart) push_exp(cyc + 1);
        @(negedge clk);
        result_ack = 1'b0;
        chk("ack_valid_drop", result_valid, 0);
        chk("ack_busy_idle", busy, 0);
        @(negedge clk);
        chk("restart_busy", busy, restart);
    endtask

    task automatic set_per(input int r, input int g, input int b);
        per_r = r;
        per_g = g;
        per_b = b;
    endtask

    initial begin : driver
        logic [1:0]    c_snap;
        logic [CW-1:0] r_snap, g_snap, b_snap;
        int            bad;
        int            n;

        reset = 1'b1; en = 1'b0; start = 1'b0; result_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Red dominant
        set_per(5, 25, 25);
        start_scan(0); wait_valid(); do_ack(0, 2);

        // All channels exactly at threshold: colour held from previous scan
        set_per(10, 10, 10);
        start_scan(0); wait_valid(); do_ack(0, 0);

        // Dark scan straight after reset reports clear
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); reset = 1'b0; m_prev = 0;
        repeat (2) @(negedge clk);
        set_per(25, 25, 25);
        start_scan(0); wait_valid(); do_ack(0, 1);

        // Green saturates
        set_per(0, 2, 50);
        start_scan(0); wait_valid(); do_ack(0, 3);

        // Random scans with stray start/ack pulses mid-scan
        for (int i = 0; i < 8; i++) begin
            set_per(ptab[$urandom_range(0, 11)], ptab[$urandom_range(0, 11)],
                    ptab[$urandom_range(0, 11)]);
            start_scan(0);
            repeat ($urandom_range(5, LAT - 40)) @(negedge clk);
            start = 1'b1; result_ack = 1'b1;
            @(negedge clk);
            start = 1'b0; result_ack = 1'b0;
            wait_valid();
            do_ack(0, $urandom_range(0, 4));
        end

        // Continuous mode: result held indefinitely without ack
        set_per(8, 40, 100);
        start_scan(1); wait_valid();
        c_snap = color; r_snap = red_cnt; g_snap = green_cnt; b_snap = blue_cnt;
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (color != c_snap || red_cnt != r_snap || green_cnt != g_snap ||
                blue_cnt != b_snap || !result_valid || busy) bad++;
        end
        chk("hold_stable", bad, 0);
        set_per(200, 50, 4);
        do_ack(1, 0);
        repeat (100) @(negedge clk);
        en = 1'b0;
        wait_valid(); do_ack(0, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || result_valid) bad++;
        end
        chk("no_restart_after_en_drop", bad, 0);

        // start and ack together in HOLD: ack wins
        set_per(4, 4, 100);
        start_scan(0); wait_valid();
        start = 1'b1; result_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; result_ack = 1'b0;
        chk("sa_valid_drop", result_valid, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || result_valid) bad++;
        end
        chk("sa_start_ignored", bad, 0);

        // Reset during blue measurement, then a clean full-length scan
        set_per(20, 20, 5);
        start_scan(0);
        n = 0;
        while (filter != 2'd1 && n < LAT) begin
            @(negedge clk);
            n++;
        end
        chk("reached_blue", filter, 1);
        repeat (S + 50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        sb.delete();
        m_prev = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        set_per(40, 4, 40);
        start_scan(0); wait_valid(); do_ack(0, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
